// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter sequence controller: the state type
// and the default counter width.
package counter_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/counter_seq_ctrl.sv
// Sequences an external load/up counter from a start value to an end value,
// reporting completion, abort and the number of count transitions taken.
module counter_seq_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_end,
  input  logic             cmd_up,
  input  logic             abort,
  output logic             load,
  output logic [WIDTH-1:0] load_data,
  output logic             up,
  input  logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [WIDTH:0]   steps
);

  localparam logic [WIDTH:0] STEP_ONE = {{WIDTH{1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] end_q, end_d;
  logic             up_q, up_d;
  logic [WIDTH:0]   steps_q, steps_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;

  always_comb begin
    state_d   = state_q;
    start_d   = start_q;
    end_d     = end_q;
    up_d      = up_q;
    steps_d   = steps_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    // Default is "hold": reload the counter with its own value.
    cmd_ready = 1'b0;
    busy      = 1'b0;
    load      = 1'b1;
    load_data = count;
    up        = 1'b0;

    if (!reset) begin
      case (state_q)
        IDLE: begin
          cmd_ready = 1'b1;
          if (cmd_valid) begin
            start_d = cmd_start;
            end_d   = cmd_end;
            up_d    = cmd_up;
            steps_d = '0;
            state_d = LOAD;
          end
        end
        LOAD: begin
          busy = 1'b1;
          up   = up_q;
          if (abort) begin
            aborted_d = 1'b1;
            state_d   = IDLE;
          end else begin
            load_data = start_q;
            state_d   = RUN;
          end
        end
        RUN: begin
          busy = 1'b1;
          up   = up_q;
          // Abort wins over terminal-count detection in the same cycle.
          if (abort) begin
            aborted_d = 1'b1;
            state_d   = IDLE;
          end else if (count == end_q) begin
            load_data = end_q;
            done_d    = 1'b1;
            state_d   = DONE;
          end else begin
            load    = 1'b0;
            steps_d = steps_q + STEP_ONE;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      start_q   <= '0;
      end_q     <= '0;
      up_q      <= 1'b0;
      steps_q   <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      end_q     <= end_d;
      up_q      <= up_d;
      steps_q   <= steps_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign done    = done_q;
  assign aborted = aborted_q;
  assign steps   = steps_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Randomised scoreboard bench for counter_seq_ctrl driving a behavioural
// load/up counter; expected pulses are queued at each accepted command.
module tb_counter_seq_ctrl;
  import counter_ctrl_pkg::*;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [W-1:0] cmd_start = '0;
  logic [W-1:0] cmd_end = '0;
  logic         cmd_up = 1'b0;
  logic         abort = 1'b0;
  logic         load;
  logic [W-1:0] load_data;
  logic         up;
  logic [W-1:0] count = '0;
  logic         busy;
  logic         done;
  logic         aborted;
  logic [W:0]   steps;

  counter_seq_ctrl #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_end(cmd_end), .cmd_up(cmd_up),
    .abort(abort), .load(load), .load_data(load_data), .up(up),
    .count(count), .busy(busy), .done(done), .aborted(aborted),
    .steps(steps)
  );

  always #5 clock = ~clock;

  // External counter: counts every clock unless loaded, wraps naturally.
  always @(posedge clock) count <= load ? load_data : (up ? count + 1'b1 : count - 1'b1);

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit         is_abort;
    int         cyc;
    int         steps;
    int         cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;
  int   model_count = 0;
  int   last_end = -10;
  bit   last_junk = 0;
  int   txn_no = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, req, cyc);
    end
  endtask

  function automatic int ref_steps(int s, int e, bit u);
    return u ? (e - s + MOD) % MOD : (s - e + MOD) % MOD;
  endfunction

  function automatic int ref_pos(int s, int k, bit u);
    return u ? (s + k) % MOD : (s - k + MOD) % MOD;
  endfunction

  // Monitor: every done/aborted pulse must match the oldest expectation.
  always @(negedge clock) begin
    if (mon_en) begin
      if (done === 1'b1 || aborted === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", 32'({done, aborted}), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pulse_exclusive", 32'(done & aborted), 32'd0);
          chk("pulse_kind_aborted", 32'(aborted), 32'(mon_e.is_abort));
          chk("pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
          chk("steps", 32'(steps), 32'(mon_e.steps));
          chk("final_count", 32'(count), 32'(mon_e.cnt));
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
        mon_e = exp_q.pop_front();
        chk("missing_pulse", 32'd0, 32'd1);
      end
    end
  end

  task automatic wait_hs(output int h, output bit ok);
    int w;
    bit got;
    w = 0;
    got = 0;
    while (!got && w < 20) begin
      @(negedge clock);
      if (cmd_ready === 1'b1) got = 1;
      else w++;
    end
    ok = got;
    h = cyc;
    if (!got) begin
      chk("handshake_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
    end
  endtask

  // abort_at: -2 none, -1 during LOAD, k>=0 in the k-th RUN cycle.
  task automatic issue(input int s, input int e, input bit u, input int abort_at, input bit junk);
    int   h, n, a_cyc, e_cyc;
    bit   ok;
    exp_t x;
    @(posedge clock); #1;
    cmd_valid = 1'b1;
    cmd_start = W'(s);
    cmd_end   = W'(e);
    cmd_up    = u;
    wait_hs(h, ok);
    if (!ok) return;
    txn_no++;
    $display("txn %0d start=%0d end=%0d up=%0d abort_at=%0d junk=%0d hs_cycle=%0d",
             txn_no, s, e, u, abort_at, junk, h);
    chk("held_count", 32'(count), 32'(model_count));
    if (last_junk) chk("bp_accept_cycle", 32'(h), 32'(last_end + 1));
    n = ref_steps(s, e, u);
    a_cyc = -1;
    if (abort_at == -2) begin
      x.is_abort = 0; x.steps = n; x.cnt = e; e_cyc = h + n + 3;
    end else if (abort_at == -1) begin
      a_cyc = h + 1;
      x.is_abort = 1; x.steps = 0; x.cnt = model_count; e_cyc = h + 2;
    end else begin
      a_cyc = h + 2 + abort_at;
      x.is_abort = 1; x.steps = abort_at; x.cnt = ref_pos(s, abort_at, u); e_cyc = a_cyc + 1;
    end
    x.cyc = e_cyc;
    exp_q.push_back(x);

    @(posedge clock); #1;
    if (junk) begin
      cmd_start = W'($urandom);
      cmd_end   = W'($urandom);
      cmd_up    = 1'($urandom);
    end else begin
      cmd_valid = 1'b0;
    end
    for (int c = h + 1; c <= e_cyc; c++) begin
      abort = (abort_at != -2) && (c == a_cyc);
      @(negedge clock);
      chk("cmd_ready", 32'(cmd_ready), 32'(x.is_abort && c == e_cyc));
      chk("busy", 32'(busy), 32'(c < e_cyc));
      if (c < e_cyc) begin
        @(posedge clock); #1;
      end
    end
    abort = 1'b0;
    model_count = x.cnt;
    last_end = e_cyc;
    last_junk = junk;
  endtask

  task automatic reset_mid_run();
    int h;
    bit ok;
    @(posedge clock); #1;
    cmd_valid = 1'b1; cmd_start = 4'd3; cmd_end = 4'd12; cmd_up = 1'b1;
    wait_hs(h, ok);
    if (!ok) return;
    $display("txn reset_mid_run start=3 end=12 up=1 hs_cycle=%0d", h);
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    repeat (7) @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    chk("rst_run_count", 32'(count), 32'd9);
    chk("rst_load", 32'(load), 32'd1);
    chk("rst_load_data", 32'(load_data), 32'd9);
    chk("rst_up", 32'(up), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_steps_cleared", 32'(steps), 32'd0);
    chk("rst_cmd_ready_after", 32'(cmd_ready), 32'd1);
    repeat (4) @(negedge clock);
    chk("rst_count_held", 32'(count), 32'd9);
    model_count = 9;
    last_junk = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, e, n, mode;
    bit u;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_load", 32'(load), 32'd1);
    chk("reset_load_data", 32'(load_data), 32'd0);
    chk("reset_up", 32'(up), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_aborted", 32'(aborted), 32'd0);
    chk("reset_steps", 32'(steps), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clock);
    chk("ready_after_reset", 32'(cmd_ready), 32'd1);

    issue(7, 11, 1, -2, 0);
    issue(2, 14, 0, -2, 0);
    issue(5, 5, 1, -2, 0);
    issue(0, 15, 1, 6, 0);
    issue(14, 1, 1, -2, 1);
    issue(3, 9, 0, -2, 0);
    issue(4, 8, 1, -1, 0);
    issue(10, 13, 1, 3, 0);
    issue(6, 6, 0, 0, 0);
    reset_mid_run();

    for (int i = 0; i < 40; i++) begin
      s = int'($urandom_range(0, MOD - 1));
      e = int'($urandom_range(0, MOD - 1));
      u = 1'($urandom);
      mode = int'($urandom_range(0, 3));
      n = ref_steps(s, e, u);
      if (mode == 3) issue(s, e, u, int'($urandom_range(0, n + 1)) - 1, 0);
      else issue(s, e, u, -2, mode == 2);
    end
    cmd_valid = 1'b0;

    repeat (5) @(negedge clock);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
